// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue pairing dual-word cache responses with the PC captured at request time.
// Define FETCH_QUEUE_BYPASS_EN to present an accepted response on slot0 in its arrival cycle when the queue is empty.
module fetch_queue #(
    parameter int DEPTH      = 16,
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_fire,
    input  logic [PC_WIDTH-1:0]       req_pc,
    input  logic                      req_dual,
    input  logic                      resp_valid,
    input  logic [2*INST_WIDTH-1:0]   resp_data,
    input  logic                      flush,
    output logic                      ready_to_fetch,
    output logic [1:0]                out_valid,
    output logic [INST_WIDTH-1:0]     out_inst0,
    output logic [INST_WIDTH-1:0]     out_inst1,
    output logic [PC_WIDTH-1:0]       out_pc0,
    output logic [PC_WIDTH-1:0]       out_pc1,
    input  logic [1:0]                deq_cnt,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
    logic [AW-1:0]         head, tail, head_nx1;
    logic                  pv, pdual, pdrop;
    logic [PC_WIDTH-1:0]   ppc, ppc4, w0_pc;
    logic [INST_WIDTH-1:0] inst0, inst1, w0_inst;
    logic                  acc, byp, skip;
    logic [1:0]            n_enq, n_wr, hdeq;

    assign {inst1, inst0} = resp_data;
    assign ppc4     = ppc + PC_WIDTH'(4);
    assign head_nx1 = head + AW'(1);
    assign acc      = resp_valid & pv & ~pdrop & ~flush;
    assign n_enq    = acc ? (pdual ? 2'd2 : 2'd1) : 2'd0;
`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = acc && (count == '0);
`else
    assign byp = 1'b0;
`endif
    // A bypassed word consumed by decode is never written; the rest land starting at tail.
    assign skip    = byp & deq_cnt[0];
    assign hdeq    = byp ? 2'd0 : deq_cnt;
    assign n_wr    = n_enq - (byp ? deq_cnt : 2'd0);
    assign w0_inst = skip ? inst1 : inst0;
    assign w0_pc   = skip ? ppc4 : ppc;

    assign out_valid = byp ? 2'b01 : {count >= CW'(2), count != '0};
    assign out_inst0 = byp ? inst0 : inst_mem[head];
    assign out_pc0   = byp ? ppc : pc_mem[head];
    assign out_inst1 = inst_mem[head_nx1];
    assign out_pc1   = pc_mem[head_nx1];

    // Outstanding dual request reserves two slots unless its data is landing now.
    assign ready_to_fetch = (CW'(DEPTH) - count) >= ((pv & ~pdrop & ~resp_valid) ? CW'(4) : CW'(2));

    always_ff @(posedge clk) begin
        if (n_wr != 2'd0) begin
            inst_mem[tail] <= w0_inst;
            pc_mem[tail]   <= w0_pc;
        end
        if (n_wr == 2'd2) begin
            inst_mem[tail + AW'(1)] <= inst1;
            pc_mem[tail + AW'(1)]   <= ppc4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(hdeq);
            tail  <= tail + AW'(n_wr);
            count <= count + CW'(n_enq) - CW'(deq_cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv    <= 1'b0;
            ppc   <= '0;
            pdual <= 1'b0;
            pdrop <= 1'b0;
        end else if (req_fire) begin
            pv    <= 1'b1;
            ppc   <= req_pc;
            pdual <= req_dual;
            pdrop <= 1'b0;
        end else if (resp_valid) begin
            pv <= 1'b0;
        end else if (flush) begin
            pdrop <= 1'b1;
        end
    end

    a_resp_needs_pending: assert property (@(posedge clk) disable iff (reset) resp_valid |-> pv);
    a_one_outstanding:    assert property (@(posedge clk) disable iff (reset) (req_fire && pv) |-> resp_valid);
    a_no_overflow:        assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
    a_deq_le_valid:       assert property (@(posedge clk) disable iff (reset)
                              !flush |-> deq_cnt <= (2'(out_valid[0]) + 2'(out_valid[1])));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=16).
module tb_fetch_queue;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_fire;
    logic [31:0] req_pc;
    logic        req_dual;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        flush;
    logic        ready_to_fetch;
    logic [1:0]  out_valid;
    logic [31:0] out_inst0, out_inst1, out_pc0, out_pc1;
    logic [1:0]  deq_cnt;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .INST_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_fire(req_fire), .req_pc(req_pc), .req_dual(req_dual),
        .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
        .ready_to_fetch(ready_to_fetch), .out_valid(out_valid),
        .out_inst0(out_inst0), .out_inst1(out_inst1), .out_pc0(out_pc0), .out_pc1(out_pc1),
        .deq_cnt(deq_cnt), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    // Advance one cycle, then clear all strobes so each cycle drives only what it sets.
    task automatic tick;
        @(posedge clk);
        #1;
        req_fire = 0; req_dual = 0; req_pc = '0; resp_valid = 0; resp_data = '0; flush = 0; deq_cnt = 0;
        #1;
    endtask

    task automatic fire(input logic [31:0] pc, input logic dual);
        req_fire = 1; req_pc = pc; req_dual = dual;
    endtask

    task automatic respond(input logic [31:0] pc);
        resp_valid = 1; resp_data = {inst_of(pc + 32'd4), inst_of(pc)};
    endtask

    int          q[$];
    int          sz, d, hm, seen, enq_tot;
    logic        pend;
    logic [31:0] pend_pc, next_pc;

    initial begin
        reset = 1;
        req_fire = 0; req_dual = 0; req_pc = '0; resp_valid = 0; resp_data = '0; flush = 0; deq_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", count, 0);
        check("reset_valid", out_valid, 2'b00);
        check("reset_ready", ready_to_fetch, 1);
        reset = 0;
        tick;

        // Basic dual enqueue
        fire(32'h1000, 1);
        #1 check("t1_ready_idle", ready_to_fetch, 1);
        tick;
        resp_valid = 1; resp_data = {32'hB, 32'hA};
        #1 check("t1_ready_landing", ready_to_fetch, 1);
`ifndef FETCH_QUEUE_BYPASS_EN
        check("t1_not_visible_yet", out_valid, 2'b00);
`endif
        tick;
        check("t1_count", count, 2);
        check("t1_valid", out_valid, 2'b11);
        check("t1_pc0", out_pc0, 32'h1000);
        check("t1_inst0", out_inst0, 32'hA);
        check("t1_pc1", out_pc1, 32'h1004);
        check("t1_inst1", out_inst1, 32'hB);
        deq_cnt = 2;
        tick;
        check("t1_drained", count, 0);

        // Back-to-back requests
        fire(32'h2000, 1);
        tick;
        fire(32'h2008, 0); respond(32'h2000);
        tick;
        check("t2_pc0", out_pc0, 32'h2000);
        check("t2_pc1", out_pc1, 32'h2004);
        check("t2_inst1", out_inst1, inst_of(32'h2004));
        respond(32'h2008); deq_cnt = 2;
        tick;
        check("t2_valid_single", out_valid, 2'b01);
        check("t2_pc_single", out_pc0, 32'h2008);
        check("t2_inst_single", out_inst0, inst_of(32'h2008));
        deq_cnt = 1;
        tick;
        check("t2_empty", count, 0);

        // Fill to full and backpressure
        for (int i = 0; i < 7; i++) begin
            fire(32'h6000 + 32'(8 * i), 1);
            tick;
            respond(32'h6000 + 32'(8 * i));
            tick;
        end
        check("t3_count14", count, 14);
        check("t3_ready14_idle", ready_to_fetch, 1);
        fire(32'h6038, 1);
        tick;
        check("t3_ready_pending", ready_to_fetch, 0);
        respond(32'h6038);
        #1 check("t3_ready_landing", ready_to_fetch, 1);
        tick;
        check("t3_count_full", count, 16);
        check("t3_ready_full", ready_to_fetch, 0);
        check("t3_valid_full", out_valid, 2'b11);
        deq_cnt = 2;
        tick;
        check("t3_count_after_deq", count, 14);
        check("t3_ready_after_deq", ready_to_fetch, 1);
        for (int k = 0; k < 7; k++) begin
            check("t3_drain_pc0", out_pc0, 32'h6008 + 32'(8 * k));
            check("t3_drain_pc1", out_pc1, 32'h600C + 32'(8 * k));
            deq_cnt = 2;
            tick;
        end
        check("t3_drained", count, 0);

        // Wrap-around with mixed dequeue widths, head restarted at 0
        reset = 1;
        tick;
        reset = 0;
        tick;
        hm = 0; seen = 0; enq_tot = 0; pend = 0; pend_pc = '0; next_pc = 32'h8000;
        for (int it = 0; it < 400; it++) begin
            if (enq_tot >= 3 * DEPTH && q.size() == 0 && !pend) break;
            sz = q.size();
            check("t4_valid", out_valid, {sz >= 2, sz >= 1});
            if (sz >= 1) begin
                check("t4_pc0", out_pc0, 32'(q[0]));
                check("t4_inst0", out_inst0, inst_of(32'(q[0])));
            end
            if (sz >= 2) begin
                check("t4_pc1", out_pc1, 32'(q[1]));
                check("t4_inst1", out_inst1, inst_of(32'(q[1])));
                if (hm == DEPTH - 1) seen++;
            end
            d = (it % 3 == 0) ? 1 : 2;
            if (d > sz) d = sz;
            deq_cnt = 2'(d);
            for (int j = 0; j < d; j++) void'(q.pop_front());
            hm = (hm + d) % DEPTH;
            if (pend) begin
                respond(pend_pc);
                q.push_back(int'(pend_pc));
                q.push_back(int'(pend_pc + 32'd4));
            end
            pend = 0;
            if (enq_tot < 3 * DEPTH && q.size() <= DEPTH - 2 && sz <= DEPTH - 2) begin
                #1 check("t4_ready_when_firing", ready_to_fetch, 1);
                fire(next_pc, 1);
                pend = 1; pend_pc = next_pc;
                next_pc += 32'd8;
                enq_tot += 2;
            end
            tick;
        end
        check("t4_all_drained", count, 0);
        check("t4_enqueued_total", 32'(enq_tot), 32'(3 * DEPTH));
        check("t4_slot1_at_wrap", 32'(seen > 0), 1);

        // Flush drops queue and the in-flight response
        fire(32'h2F00, 1);
        tick;
        respond(32'h2F00);
        tick;
        fire(32'h3000, 0);
        tick;
        flush = 1;
        tick;
        check("t5_flush_count", count, 0);
        check("t5_ready_dropping", ready_to_fetch, 1);
        respond(32'h3000);
        tick;
        check("t5_dropped_count", count, 0);
        check("t5_dropped_valid", out_valid, 2'b00);

        // Request issued in the flush cycle survives
        fire(32'h3100, 0);
        tick;
        respond(32'h3100); flush = 1; fire(32'h4000, 1);
        tick;
        check("t5_post_flush_empty", count, 0);
        resp_valid = 1; resp_data = {32'h44, 32'h40};
        tick;
        check("t5_redirect_count", count, 2);
        check("t5_redirect_pc0", out_pc0, 32'h4000);
        check("t5_redirect_inst0", out_inst0, 32'h40);
        check("t5_redirect_pc1", out_pc1, 32'h4004);
        check("t5_redirect_inst1", out_inst1, 32'h44);
        deq_cnt = 2;
        tick;

`ifdef FETCH_QUEUE_BYPASS_EN
        fire(32'h5000, 1);
        tick;
        resp_valid = 1; resp_data = {32'hD, 32'hC}; deq_cnt = 1;
        #1;
        check("t6_byp_valid", out_valid, 2'b01);
        check("t6_byp_inst0", out_inst0, 32'hC);
        check("t6_byp_pc0", out_pc0, 32'h5000);
        tick;
        check("t6_count", count, 1);
        check("t6_pc0", out_pc0, 32'h5004);
        check("t6_inst0", out_inst0, 32'hD);
        deq_cnt = 1;
        tick;
`endif

        // Asynchronous reset mid-operation with a request pending
        fire(32'h7000, 1);
        tick;
        respond(32'h7000);
        tick;
        check("t7_loaded", count, 2);
        fire(32'h7008, 1);
        #3 reset = 1;
        #1;
        check("t7_async_count", count, 0);
        check("t7_async_valid", out_valid, 2'b00);
        check("t7_async_ready", ready_to_fetch, 1);
        tick;
        reset = 0;
        tick;
        check("t7_after_reset", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
